prf_state_mp: RTL and testbench
===============================

PRF_STATE_MP -- requirements
Module: prf_state_mp

Interface
REQ-001 SHALL have parameter NUM_PHYS_REG_P, default 128, number of physical registers (power of 2, >=32).
REQ-002 SHALL have parameter WORD_SIZE_P, default 16, data width.
REQ-003 SHALL have parameter NUM_WR_P, default 4, execute write-back ports.
REQ-004 SHALL have parameter NUM_RD_P, default 2, issue read-port pairs (rs1/rs2 each).
REQ-005 SHALL have parameter NUM_CMT_P, default 2, commit lanes (register clear plus flag update).
REQ-006 SHALL have parameter NUM_FLAGS_P, default 4, and NUM_ARCH_P, default 16, registers valid after init.
REQ-007 SHALL use one clock; reset is synchronous and active-high; ports named clk_i and reset_i.
REQ-008 Ports, with A = clog2(NUM_PHYS_REG_P):
  clk_i  in  1  clock
  reset_i  in  1  synchronous active-high reset
  ready_o  out  1  init sweep complete
  exe_w_v_i  in  NUM_WR_P  write-back valid per port
  exe_addr_i  in  NUM_WR_P x A  write-back address
  exe_data_i  in  NUM_WR_P x WORD_SIZE_P  write-back data
  cmt_clr_v_i  in  NUM_CMT_P  commit clear valid per lane
  cmt_clr_addr_i  in  NUM_CMT_P x A  register to invalidate
  cmt_flag_v_i  in  NUM_CMT_P  flag update valid per lane
  cmt_flag_i  in  NUM_CMT_P x 2*NUM_FLAGS_P  {keep-mask, value}
  flag_o  out  NUM_FLAGS_P  committed flags
  flush_i  in  1  pipeline flush
  flush_valid_i  in  NUM_PHYS_REG_P  valid vector restored on flush
  rd_addr_i  in  NUM_RD_P x 2 x A  rs1/rs2 addresses
  rd_valid_o  out  NUM_RD_P x 2  operand ready
  rd_data_o  out  NUM_RD_P x 2 x WORD_SIZE_P  operand data
  wr_conflict_o  out  1  sticky: two write ports hit the same address in one cycle

Function
REQ-009 FSM SHALL have states INIT and RUN; reset enters INIT with sweep counter = 0.
REQ-010 In INIT, each cycle SHALL write 0 to reg[counter], set valid[counter] = (counter < NUM_ARCH_P), then increment; last index -> RUN on next edge; INIT lasts exactly NUM_PHYS_REG_P cycles.
REQ-011 ready_o SHALL be 1 only in RUN; all exe, cmt, flush inputs SHALL be ignored in INIT.
REQ-012 In RUN, for each asserted exe_w_v_i[k], reg[addr] <= data and valid[addr] <= 1 at next edge.
REQ-013 Same-address multi-write SHALL resolve to highest port index, and SHALL set wr_conflict_o, held until reset.
REQ-014 Each cmt_clr_v_i[j] SHALL clear valid[addr] at next edge; clear beats a same-cycle write to that address (data still written).
REQ-015 Flag lanes SHALL apply in lane order 0..NUM_CMT_P-1: f = (mask & f) | (~mask & value); flag_o is the registered result.
REQ-016 flush_i in RUN SHALL load valid <= flush_valid_i, overriding all same-cycle writes and clears to valid; data writes and flag updates still occur.
REQ-017 Reads SHALL be combinational: rd_valid_o/rd_data_o from array, overridden by any same-cycle exe write to that address (highest port wins); no forwarding from commit clears or flush.
REQ-018 In INIT, rd_valid_o SHALL be 0 for all ports.

Reset
REQ-019 Reset SHALL force INIT, counter 0, flag_o = 0, wr_conflict_o = 0, ready_o = 0, valid = all 0; reset mid-RUN or mid-INIT SHALL restart the full sweep.

Structure
REQ-020 NUM_PHYS_REG, WORD_SIZE_P, NUM_FLAGS and the flag-update struct {mask, value} SHALL live in Purple_Jade_pkg; module parameters default to them.
REQ-021 Read forwarding SHALL be one sub-module, prf_fwd_mux, instantiated 2*NUM_RD_P times.

Verification
REQ-022 Reset, hold 128 cycles -> ready_o rises at cycle 128; then valid 0..15 = 1, 16..127 = 0, all data 0.
REQ-023 Port 0 and port 3 write addr 40 (0x1111, 0x3333) while reading 40 -> rd_data 0x3333, valid 1; next cycle array 0x3333; wr_conflict_o = 1.
REQ-024 Write addr 50 and clear addr 50 same cycle -> next cycle rd_valid 0, data = written value.
REQ-025 Flags 0; lane0 {mask 0, val 0xF}, lane1 {mask 0xC, val 0x0} -> flag_o = 0xC.
REQ-026 Flush with flush_valid_i = 0xFFFF while writing addr 100 -> valid[100] = 0, reg[100] updated.
REQ-027 Assert reset at INIT cycle 60 -> sweep restarts, ready_o rises 128 cycles after reset release.

Source files
------------

// File: rtl/Purple_Jade_pkg.sv
// Shared sizing, FSM state and flag-update types for the physical register file state block.
// Types only; no latency or backpressure.
package Purple_Jade_pkg;

    localparam int NUM_PHYS_REG = 128;
    localparam int WORD_SIZE_P  = 16;
    localparam int NUM_FLAGS    = 4;
    localparam int NUM_ARCH     = 16;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } prf_state_t;

    // Set mask bits keep the current flag; clear mask bits take the new value.
    typedef struct packed {
        logic [NUM_FLAGS-1:0] mask;
        logic [NUM_FLAGS-1:0] value;
    } flag_upd_t;

endpackage

// File: rtl/prf_state_mp_if.sv
// Write-back, commit, flush and read-port bundle of the register file state block.
// No flow control: every port is accepted in the cycle it is presented.
interface prf_state_mp_if
    import Purple_Jade_pkg::*;
#(
    parameter int NUM_PHYS_REG_P = NUM_PHYS_REG,
    parameter int WORD_SIZE_P    = Purple_Jade_pkg::WORD_SIZE_P,
    parameter int NUM_WR_P       = 4,
    parameter int NUM_RD_P       = 2,
    parameter int NUM_CMT_P      = 2,
    parameter int NUM_FLAGS_P    = NUM_FLAGS
);
    localparam int A = $clog2(NUM_PHYS_REG_P);

    logic                                       ready_o;
    logic [NUM_WR_P-1:0]                        exe_w_v_i;
    logic [NUM_WR_P-1:0][A-1:0]                 exe_addr_i;
    logic [NUM_WR_P-1:0][WORD_SIZE_P-1:0]       exe_data_i;
    logic [NUM_CMT_P-1:0]                       cmt_clr_v_i;
    logic [NUM_CMT_P-1:0][A-1:0]                cmt_clr_addr_i;
    logic [NUM_CMT_P-1:0]                       cmt_flag_v_i;
    logic [NUM_CMT_P-1:0][2*NUM_FLAGS_P-1:0]    cmt_flag_i;
    logic [NUM_FLAGS_P-1:0]                     flag_o;
    logic                                       flush_i;
    logic [NUM_PHYS_REG_P-1:0]                  flush_valid_i;
    logic [NUM_RD_P-1:0][1:0][A-1:0]            rd_addr_i;
    logic [NUM_RD_P-1:0][1:0]                   rd_valid_o;
    logic [NUM_RD_P-1:0][1:0][WORD_SIZE_P-1:0]  rd_data_o;
    logic                                       wr_conflict_o;

    modport master (
        input  ready_o, flag_o, rd_valid_o, rd_data_o, wr_conflict_o,
        output exe_w_v_i, exe_addr_i, exe_data_i, cmt_clr_v_i, cmt_clr_addr_i,
               cmt_flag_v_i, cmt_flag_i, flush_i, flush_valid_i, rd_addr_i
    );

    modport slave (
        output ready_o, flag_o, rd_valid_o, rd_data_o, wr_conflict_o,
        input  exe_w_v_i, exe_addr_i, exe_data_i, cmt_clr_v_i, cmt_clr_addr_i,
               cmt_flag_v_i, cmt_flag_i, flush_i, flush_valid_i, rd_addr_i
    );

endinterface

// File: rtl/prf_state_mp_fwd_mux.sv
// One operand read: array value overridden by a same-cycle write-back, highest port winning.
// Purely combinational, zero latency; no backpressure.
module prf_fwd_mux #(
    parameter int A_W         = 7,
    parameter int WORD_SIZE_P = 16,
    parameter int NUM_WR_P    = 4
) (
    input  logic                                  run,
    input  logic [A_W-1:0]                        rd_addr,
    input  logic                                  arr_valid,
    input  logic [WORD_SIZE_P-1:0]                arr_data,
    input  logic [NUM_WR_P-1:0]                   exe_w_v,
    input  logic [NUM_WR_P-1:0][A_W-1:0]          exe_addr,
    input  logic [NUM_WR_P-1:0][WORD_SIZE_P-1:0]  exe_data,
    output logic                                  rd_valid,
    output logic [WORD_SIZE_P-1:0]                rd_data
);

    always_comb begin
        rd_valid = arr_valid;
        rd_data  = arr_data;
        // Ascending scan so the highest matching port is the one left standing.
        for (int k = 0; k < NUM_WR_P; k++) begin
            if (run && exe_w_v[k] && (exe_addr[k] == rd_addr)) begin
                rd_valid = 1'b1;
                rd_data  = exe_data[k];
            end
        end
        if (!run) begin
            rd_valid = 1'b0;
        end
    end

endmodule

// File: rtl/prf_state_mp.sv
// Physical register file with valid bits, commit flags and an init sweep of NUM_PHYS_REG_P cycles.
// Writes/clears/flush land next edge, reads are combinational; inputs are ignored until ready_o.
module prf_state_mp
    import Purple_Jade_pkg::*;
#(
    parameter int NUM_PHYS_REG_P = NUM_PHYS_REG,
    parameter int WORD_SIZE_P    = Purple_Jade_pkg::WORD_SIZE_P,
    parameter int NUM_WR_P       = 4,
    parameter int NUM_RD_P       = 2,
    parameter int NUM_CMT_P      = 2,
    parameter int NUM_FLAGS_P    = NUM_FLAGS,
    parameter int NUM_ARCH_P     = NUM_ARCH
) (
    input  logic          clk_i,
    input  logic          reset_i,
    prf_state_mp_if.slave bus
);

    localparam int A = $clog2(NUM_PHYS_REG_P);

    prf_state_t                 state;
    logic [A-1:0]               cnt;
    logic                       ready_q;
    logic                       conflict_q;
    logic [NUM_FLAGS_P-1:0]     flag_q;
    logic [NUM_PHYS_REG_P-1:0]  valid_q;
    logic [WORD_SIZE_P-1:0]     regs [NUM_PHYS_REG_P];

    logic [NUM_PHYS_REG_P-1:0]  valid_nxt;
    logic [NUM_FLAGS_P-1:0]     flag_nxt;
    logic                       conflict_now;
    logic                       run;

    assign run = (state == ST_RUN);

    // Priority on valid: write sets, commit clear beats write, flush replaces everything.
    always_comb begin
        valid_nxt = valid_q;
        for (int k = 0; k < NUM_WR_P; k++) begin
            if (bus.exe_w_v_i[k]) valid_nxt[bus.exe_addr_i[k]] = 1'b1;
        end
        for (int j = 0; j < NUM_CMT_P; j++) begin
            if (bus.cmt_clr_v_i[j]) valid_nxt[bus.cmt_clr_addr_i[j]] = 1'b0;
        end
        if (bus.flush_i) valid_nxt = bus.flush_valid_i;
    end

    always_comb begin
        flag_nxt = flag_q;
        for (int j = 0; j < NUM_CMT_P; j++) begin
            if (bus.cmt_flag_v_i[j]) begin
                flag_nxt = (bus.cmt_flag_i[j][2*NUM_FLAGS_P-1:NUM_FLAGS_P] & flag_nxt)
                         | (~bus.cmt_flag_i[j][2*NUM_FLAGS_P-1:NUM_FLAGS_P]
                            & bus.cmt_flag_i[j][NUM_FLAGS_P-1:0]);
            end
        end
    end

    always_comb begin
        conflict_now = 1'b0;
        for (int k = 0; k < NUM_WR_P; k++) begin
            for (int m = k + 1; m < NUM_WR_P; m++) begin
                if (bus.exe_w_v_i[k] && bus.exe_w_v_i[m] &&
                    (bus.exe_addr_i[k] == bus.exe_addr_i[m])) begin
                    conflict_now = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state      <= ST_INIT;
            cnt        <= '0;
            ready_q    <= 1'b0;
            conflict_q <= 1'b0;
            flag_q     <= '0;
            valid_q    <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    valid_q[cnt] <= (int'(cnt) < NUM_ARCH_P);
                    cnt          <= cnt + 1'b1;
                    if (&cnt) begin
                        state   <= ST_RUN;
                        ready_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    valid_q <= valid_nxt;
                    flag_q  <= flag_nxt;
                    if (conflict_now) conflict_q <= 1'b1;
                end
                default: begin
                    state   <= ST_INIT;
                    cnt     <= '0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Data array is not reset; the init sweep zeroes it. Later ports overwrite earlier ones.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            if (state == ST_INIT) begin
                regs[cnt] <= '0;
            end else begin
                for (int k = 0; k < NUM_WR_P; k++) begin
                    if (bus.exe_w_v_i[k]) regs[bus.exe_addr_i[k]] <= bus.exe_data_i[k];
                end
            end
        end
    end

    logic                   rd_v [NUM_RD_P][2];
    logic [WORD_SIZE_P-1:0] rd_d [NUM_RD_P][2];

    for (genvar p = 0; p < NUM_RD_P; p++) begin : g_rd
        for (genvar s = 0; s < 2; s++) begin : g_op
            prf_fwd_mux #(
                .A_W         (A),
                .WORD_SIZE_P (WORD_SIZE_P),
                .NUM_WR_P    (NUM_WR_P)
            ) u_fwd (
                .run       (run),
                .rd_addr   (bus.rd_addr_i[p][s]),
                .arr_valid (valid_q[bus.rd_addr_i[p][s]]),
                .arr_data  (regs[bus.rd_addr_i[p][s]]),
                .exe_w_v   (bus.exe_w_v_i),
                .exe_addr  (bus.exe_addr_i),
                .exe_data  (bus.exe_data_i),
                .rd_valid  (rd_v[p][s]),
                .rd_data   (rd_d[p][s])
            );
        end
    end

    always_comb begin
        bus.rd_valid_o = '0;
        bus.rd_data_o  = '0;
        for (int p = 0; p < NUM_RD_P; p++) begin
            for (int s = 0; s < 2; s++) begin
                bus.rd_valid_o[p][s] = rd_v[p][s];
                bus.rd_data_o[p][s]  = rd_d[p][s];
            end
        end
    end

    assign bus.ready_o       = ready_q;
    assign bus.flag_o        = flag_q;
    assign bus.wr_conflict_o = conflict_q;

endmodule

// File: tb/tb_prf_state_mp.sv
// Directed bench for prf_state_mp: init sweep, forwarding, commit clear, flags, flush, reset restart.
module tb_prf_state_mp;
    import Purple_Jade_pkg::*;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    prf_state_mp_if bus ();

    prf_state_mp dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.exe_w_v_i      = '0;
        bus.exe_addr_i     = '0;
        bus.exe_data_i     = '0;
        bus.cmt_clr_v_i    = '0;
        bus.cmt_clr_addr_i = '0;
        bus.cmt_flag_v_i   = '0;
        bus.cmt_flag_i     = '0;
        bus.flush_i        = 1'b0;
        bus.flush_valid_i  = '0;
    endtask

    // Reads one register through read slot 0/rs1 with no write-back active.
    task automatic read_check(input string tag, input int addr, input logic v, input logic [15:0] d);
        bus.rd_addr_i[0][0] = 7'(addr);
        #1;
        check({tag, "_valid"}, 32'(bus.rd_valid_o[0][0]), 32'(v));
        check({tag, "_data"},  32'(bus.rd_data_o[0][0]),  32'(d));
    endtask

    initial begin
        clear_inputs();
        bus.rd_addr_i = '0;
        reset = 1'b1;
        repeat (3) tick();
        check("rst_ready",    32'(bus.ready_o), 32'd0);
        check("rst_flag",     32'(bus.flag_o), 32'd0);
        check("rst_conflict", 32'(bus.wr_conflict_o), 32'd0);
        check("rst_rdvalid",  32'(bus.rd_valid_o), 32'd0);

        // Init sweep with junk on the inputs, which must be ignored.
        reset = 1'b0;
        bus.exe_w_v_i[0]  = 1'b1;
        bus.exe_addr_i[0] = 7'd5;
        bus.exe_data_i[0] = 16'hFFFF;
        bus.cmt_flag_v_i  = 2'b01;
        bus.cmt_flag_i[0] = flag_upd_t'{mask: 4'h0, value: 4'hF};
        for (int i = 0; i < 127; i++) begin
            tick();
            if (i == 10) check("init_rdvalid", 32'(bus.rd_valid_o), 32'd0);
        end
        check("init_ready_127", 32'(bus.ready_o), 32'd0);
        tick();
        check("init_ready_128", 32'(bus.ready_o), 32'd1);
        clear_inputs();
        check("init_flag_ignored", 32'(bus.flag_o), 32'd0);

        for (int a = 0; a < 128; a++) begin
            read_check("sweep", a, (a < 16), 16'h0000);
        end

        // Two ports on one address: highest port forwarded and stored, conflict sticks.
        bus.exe_w_v_i     = 4'b1001;
        bus.exe_addr_i[0] = 7'd40;
        bus.exe_data_i[0] = 16'h1111;
        bus.exe_addr_i[3] = 7'd40;
        bus.exe_data_i[3] = 16'h3333;
        bus.rd_addr_i[0][0] = 7'd40;
        #1;
        check("fwd40_valid", 32'(bus.rd_valid_o[0][0]), 32'd1);
        check("fwd40_data",  32'(bus.rd_data_o[0][0]),  32'h3333);
        check("conflict_before", 32'(bus.wr_conflict_o), 32'd0);
        tick();
        clear_inputs();
        read_check("arr40", 40, 1'b1, 16'h3333);
        check("conflict_after", 32'(bus.wr_conflict_o), 32'd1);

        // Write plus commit clear on one address: write forwarded now, clear wins in the array.
        bus.exe_w_v_i       = 4'b0010;
        bus.exe_addr_i[1]   = 7'd50;
        bus.exe_data_i[1]   = 16'hABCD;
        bus.cmt_clr_v_i     = 2'b10;
        bus.cmt_clr_addr_i[1] = 7'd50;
        bus.rd_addr_i[0][1] = 7'd50;
        #1;
        check("fwd50_valid", 32'(bus.rd_valid_o[0][1]), 32'd1);
        check("fwd50_data",  32'(bus.rd_data_o[0][1]),  32'hABCD);
        tick();
        clear_inputs();
        read_check("clr50", 50, 1'b0, 16'hABCD);

        // Distinct-address writes on ports 1 and 2, read on the second read pair.
        bus.exe_w_v_i       = 4'b0110;
        bus.exe_addr_i[1]   = 7'd60;
        bus.exe_data_i[1]   = 16'h0606;
        bus.exe_addr_i[2]   = 7'd61;
        bus.exe_data_i[2]   = 16'h0616;
        bus.rd_addr_i[1][1] = 7'd61;
        #1;
        check("fwd61_data", 32'(bus.rd_data_o[1][1]), 32'h0616);
        tick();
        clear_inputs();
        read_check("arr60", 60, 1'b1, 16'h0606);
        read_check("arr61", 61, 1'b1, 16'h0616);

        // Flag lanes applied in order.
        bus.cmt_flag_v_i  = 2'b11;
        bus.cmt_flag_i[0] = flag_upd_t'{mask: 4'h0, value: 4'hF};
        bus.cmt_flag_i[1] = flag_upd_t'{mask: 4'hC, value: 4'h0};
        tick();
        clear_inputs();
        check("flag_two_lane", 32'(bus.flag_o), 32'hC);
        bus.cmt_flag_v_i  = 2'b01;
        bus.cmt_flag_i[0] = flag_upd_t'{mask: 4'h8, value: 4'h3};
        tick();
        clear_inputs();
        check("flag_one_lane", 32'(bus.flag_o), 32'hB);

        // Flush overrides the write's valid but not its data.
        bus.flush_i         = 1'b1;
        bus.flush_valid_i   = 128'hFFFF;
        bus.exe_w_v_i       = 4'b0100;
        bus.exe_addr_i[2]   = 7'd100;
        bus.exe_data_i[2]   = 16'h5A5A;
        bus.cmt_clr_v_i     = 2'b01;
        bus.cmt_clr_addr_i[0] = 7'd2;
        tick();
        clear_inputs();
        read_check("flush100", 100, 1'b0, 16'h5A5A);
        read_check("flush40",  40,  1'b0, 16'h3333);
        read_check("flush2",   2,   1'b1, 16'h0000);

        // Reset mid-run, then again mid-init: full sweep restarts each time.
        reset = 1'b1;
        tick();
        check("rerst_ready",    32'(bus.ready_o), 32'd0);
        check("rerst_flag",     32'(bus.flag_o), 32'd0);
        check("rerst_conflict", 32'(bus.wr_conflict_o), 32'd0);
        reset = 1'b0;
        repeat (60) tick();
        check("midinit_ready", 32'(bus.ready_o), 32'd0);
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        repeat (127) tick();
        check("restart_ready_127", 32'(bus.ready_o), 32'd0);
        tick();
        check("restart_ready_128", 32'(bus.ready_o), 32'd1);
        read_check("restart40", 40, 1'b0, 16'h0000);
        read_check("restart3",  3,  1'b1, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
